// File: rtl/gen_pipe_regs.sv
// gen_pipe_regs: multi-lane elastic register pipeline with bubble
// collapsing, synchronous flush and per-lane occupancy counters.
module gen_pipe_regs #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CHANNELS = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS*CW-1:0]    occ
);

   if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign out_valid   = in_valid;
      assign out_data    = in_data;
      assign in_ready    = out_ready;
      assign occ         = '0;
      assign unused_pass = ^{clk, rst, flush};
   end else begin : g_pipe
      for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
         logic [DEPTH-1:0] v_q;
         logic [DEPTH-1:0] v_d;
         logic [DEPTH-1:0] acc;
         logic [WIDTH-1:0] d_q [DEPTH];
         logic [CW-1:0]    occ_q;
         logic [CW-1:0]    occ_d;
         logic             in_go;
         logic             out_go;

         // acc[k]: stage k is empty or vacates this cycle
         always_comb begin
            logic a;
            a = !v_q[DEPTH-1] || out_ready[c];
            acc = '0;
            acc[DEPTH-1] = a;
            for (int k = DEPTH - 2; k >= 0; k--) begin
               a = !v_q[k] || a;
               acc[k] = a;
            end
         end

         assign in_ready[c]  = acc[0] && !flush;
         assign out_valid[c] = v_q[DEPTH-1] && !flush;
         assign in_go        = in_valid[c] && in_ready[c];
         assign out_go       = out_valid[c] && out_ready[c];

         assign out_data[c*WIDTH +: WIDTH] = d_q[DEPTH-1];
         assign occ[c*CW +: CW]            = occ_q;

         always_comb begin
            v_d = v_q;
            for (int k = 1; k < DEPTH; k++) begin
               if (acc[k]) v_d[k] = v_q[k-1];
            end
            if (acc[0]) v_d[0] = in_valid[c];
            occ_d = occ_q + CW'(in_go) - CW'(out_go);
         end

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               v_q   <= '0;
               occ_q <= '0;
            end else begin
               v_q   <= v_d;
               occ_q <= occ_d;
            end
         end

         // data moves only with a valid word; flush keeps contents
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < DEPTH; k++) d_q[k] <= RST_VAL;
            end else if (!flush) begin
               for (int k = 1; k < DEPTH; k++) begin
                  if (acc[k] && v_q[k-1]) d_q[k] <= d_q[k-1];
               end
               if (in_go) d_q[0] <= in_data[c*WIDTH +: WIDTH];
            end
         end
      end
   end

endmodule
